// File: rtl/rx_pkg.sv
// Shared UART receive definitions: FSM state encodings and bit timing helper.
// The same helper is intended for the transmit side of the link.
package rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      RECV   = 3'd2,
      STOP   = 3'd3,
      PARITY = 3'd4
   } rx_state_t;

   function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/rx_if.sv
// Serial line input and parallel strobe outputs of the UART receiver.
// slave = receiver side, master = line driver / payload consumer side.
interface rx_if #(
   parameter int PAYLOAD_BITS = 8
);
   logic                    uart_rxd;
   logic                    uart_rx_en;
   logic                    uart_rx_valid;
   logic [PAYLOAD_BITS-1:0] uart_rx_data;
   logic                    uart_rx_error;
   logic                    uart_rx_break;

   modport master (
      output uart_rxd,
      output uart_rx_en,
      input  uart_rx_valid,
      input  uart_rx_data,
      input  uart_rx_error,
      input  uart_rx_break
   );

   modport slave (
      input  uart_rxd,
      input  uart_rx_en,
      output uart_rx_valid,
      output uart_rx_data,
      output uart_rx_error,
      output uart_rx_break
   );
endinterface

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RESET_VAL sets the level both flops take while reset is held.
module rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/rx.sv
// UART receiver: 1 start, PAYLOAD_BITS data LSB-first, STOP_BITS stop.
// Define RX_PARITY_EN to expect and check one even-parity bit after the data.
module rx
   import rx_pkg::*;
#(
   parameter int BIT_RATE     = 9600,
   parameter int CLK_HZ       = 12_000_000,
   parameter int PAYLOAD_BITS = 8,
   parameter int STOP_BITS    = 1
) (
   input  logic clk,
   input  logic reset,
   rx_if.slave  bus
);
   localparam int CPB  = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int HALF = CPB / 2;
   localparam int CW   = 1 + $clog2(CPB);

   localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);
   localparam logic [3:0]    LAST_DAT = 4'(PAYLOAD_BITS - 1);
   localparam logic [3:0]    LAST_STP = 4'(STOP_BITS - 1);

   rx_state_t               state;
   logic [CW-1:0]           cnt;
   logic [3:0]              bcnt;
   logic [PAYLOAD_BITS-1:0] sreg;
   logic [PAYLOAD_BITS-1:0] data_q;
   logic                    rxd_s;
   logic                    stop_bad;
   logic                    wait_high;
   logic                    valid_q;
   logic                    error_q;
   logic                    break_q;
   logic                    mid;
   logic                    stop_now;
   logic                    brk_now;
   logic                    par_err;
`ifdef RX_PARITY_EN
   logic                    par;
`endif

   rx_sync #(.RESET_VAL(1'b1)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (bus.uart_rxd),
      .q     (rxd_s)
   );

   assign mid      = (cnt == CNT_BIT);
   assign stop_now = stop_bad | ~rxd_s;
   assign brk_now  = stop_now & (sreg == '0);
`ifdef RX_PARITY_EN
   assign par_err  = par;
`else
   assign par_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         bcnt      <= '0;
         sreg      <= '0;
         data_q    <= '0;
         stop_bad  <= 1'b0;
         wait_high <= 1'b0;
         valid_q   <= 1'b0;
         error_q   <= 1'b0;
         break_q   <= 1'b0;
`ifdef RX_PARITY_EN
         par       <= 1'b0;
`endif
      end else begin
         valid_q <= 1'b0;
         error_q <= 1'b0;
         break_q <= 1'b0;
         cnt     <= cnt + CW'(1);
         unique case (state)
            IDLE: begin
               if (rxd_s)
                  wait_high <= 1'b0;
               if (!rxd_s && bus.uart_rx_en && !wait_high) begin
                  state <= START;
                  cnt   <= '0;
               end
            end
            START: begin
               if (cnt == CNT_HALF) begin
                  cnt      <= '0;
                  bcnt     <= '0;
                  stop_bad <= 1'b0;
`ifdef RX_PARITY_EN
                  par      <= 1'b0;
`endif
                  state    <= rxd_s ? IDLE : RECV;
               end
            end
            RECV: begin
               if (mid) begin
                  cnt  <= '0;
                  bcnt <= bcnt + 4'd1;
                  sreg <= PAYLOAD_BITS'({rxd_s, sreg} >> 1);
`ifdef RX_PARITY_EN
                  par  <= par ^ rxd_s;
`endif
                  if (bcnt == LAST_DAT) begin
                     bcnt  <= '0;
`ifdef RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end
            end
`ifdef RX_PARITY_EN
            PARITY: begin
               if (mid) begin
                  cnt   <= '0;
                  par   <= par ^ rxd_s;
                  state <= STOP;
               end
            end
`endif
            STOP: begin
               if (mid) begin
                  cnt      <= '0;
                  bcnt     <= bcnt + 4'd1;
                  stop_bad <= stop_now;
                  if (bcnt == LAST_STP) begin
                     state <= IDLE;
                     if (stop_now || par_err) begin
                        error_q   <= 1'b1;
                        break_q   <= brk_now;
                        wait_high <= brk_now;
                     end else begin
                        valid_q <= 1'b1;
                        data_q  <= sreg;
                     end
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.uart_rx_valid = valid_q;
   assign bus.uart_rx_data  = data_q;
   assign bus.uart_rx_error = error_q;
   assign bus.uart_rx_break = break_q;
endmodule

// File: tb/tb_rx.sv
// Self-checking bench for rx: directed frames plus random frames against a queue model.
// Runs at a fast bit rate (23 clocks per bit) to keep the run short.
`timescale 1ns/1ps
module tb_rx;
   import rx_pkg::*;

   localparam int BIT_RATE = 521739;
   localparam int CLK_HZ   = 12_000_000;
   localparam int PB       = 8;
   localparam int SB       = 1;
   localparam int CPB      = CLK_HZ / BIT_RATE;
   localparam int HALF     = CPB / 2;
`ifdef RX_PARITY_EN
   localparam int NPAR = 1;
`else
   localparam int NPAR = 0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   last_strobe_cyc = 0;

   typedef struct {
      logic          is_err;
      logic          brk;
      logic [PB-1:0] data;
   } ev_t;

   ev_t           expq[$];
   ev_t           ev;
   logic [PB-1:0] model_data = '0;

   rx_if #(.PAYLOAD_BITS(PB)) bus ();

   rx #(
      .BIT_RATE     (BIT_RATE),
      .CLK_HZ       (CLK_HZ),
      .PAYLOAD_BITS (PB),
      .STOP_BITS    (SB)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One frame on the line; the model records the outcome if en is high at the start edge.
   task automatic send(input logic [PB-1:0] d, input bit stop_ok,
                       input bit par_ok, input bit drop_en);
      ev_t e;
      if (bus.uart_rx_en) begin
         e.is_err = !stop_ok || (NPAR == 1 && !par_ok);
         e.brk    = !stop_ok && (d == '0);
         e.data   = d;
         expq.push_back(e);
      end
      bus.uart_rxd = 1'b0;
      tick(CPB);
      if (drop_en) bus.uart_rx_en = 1'b0;
      for (int i = 0; i < PB; i++) begin
         bus.uart_rxd = d[i];
         tick(CPB);
      end
`ifdef RX_PARITY_EN
      bus.uart_rxd = (^d) ^ !par_ok;
      tick(CPB);
`endif
      for (int s = 0; s < SB; s++) begin
         bus.uart_rxd = stop_ok;
         tick(CPB);
      end
      bus.uart_rxd = 1'b1;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         model_data = '0;
      end else if (bus.uart_rx_valid || bus.uart_rx_error) begin
         last_strobe_cyc = cyc;
         chk("valid_error_exclusive", 32'(bus.uart_rx_valid & bus.uart_rx_error), 0);
         if (expq.size() == 0) begin
            chk("unexpected_strobe", 1, 0);
         end else begin
            ev = expq.pop_front();
            chk("strobe_is_error", 32'(bus.uart_rx_error), 32'(ev.is_err));
            chk("strobe_break", 32'(bus.uart_rx_break), 32'(ev.brk));
            if (!ev.is_err) model_data = ev.data;
         end
         chk("strobe_data", 32'(bus.uart_rx_data), 32'(model_data));
      end else begin
         if (bus.uart_rx_break) chk("break_without_error", 1, 0);
         if (cyc % CPB == 0)
            chk("data_hold", 32'(bus.uart_rx_data), 32'(model_data));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t0;
      int lat;
      bit st, pa, en, dr;
      bus.uart_rxd   = 1'b1;
      bus.uart_rx_en = 1'b0;
      reset = 1'b1;
      tick(3);
      chk("reset_valid", 32'(bus.uart_rx_valid), 0);
      chk("reset_error", 32'(bus.uart_rx_error), 0);
      chk("reset_break", 32'(bus.uart_rx_break), 0);
      chk("reset_data", 32'(bus.uart_rx_data), 0);
      chk("reset_state", 32'(dut.state), 32'(IDLE));
      reset = 1'b0;
      bus.uart_rx_en = 1'b1;
      tick(3 * CPB);

      t0 = cyc;
      send(8'hA5, 1, 1, 0);
      lat = last_strobe_cyc - t0;
      chk("a5_latency_window",
          32'(lat >= CPB * (PB + SB + NPAR) + HALF &&
              lat <= CPB * (PB + SB + NPAR) + HALF + 5), 1);
      chk("a5_data", 32'(bus.uart_rx_data), 32'h A5);

      send(8'h00, 1, 1, 0);
      send(8'hFF, 1, 1, 0);
      send(8'h55, 1, 1, 0);
      tick(CPB);
      chk("b2b_last_data", 32'(bus.uart_rx_data), 32'h55);

      bus.uart_rxd = 1'b0;
      tick(HALF / 2);
      bus.uart_rxd = 1'b1;
      tick(CPB);
      chk("glitch_back_idle", 32'(dut.state), 32'(IDLE));
      send(8'h3C, 1, 1, 0);
      tick(CPB);
      chk("after_glitch_data", 32'(bus.uart_rx_data), 32'h3C);

      send(8'h81, 0, 1, 0);
      tick(2 * CPB);
      chk("bad_stop_keeps_data", 32'(bus.uart_rx_data), 32'h3C);

      expq.push_back('{is_err: 1'b1, brk: 1'b1, data: '0});
      bus.uart_rxd = 1'b0;
      tick(20 * CPB);
      bus.uart_rxd = 1'b1;
      tick(2 * CPB);
      send(8'h12, 1, 1, 0);
      tick(CPB);
      chk("after_break_data", 32'(bus.uart_rx_data), 32'h12);

      bus.uart_rxd = 1'b0;
      tick(CPB);
      bus.uart_rxd = 1'b1;
      tick(CPB);
      bus.uart_rxd = 1'b0;
      tick(2 * CPB);
      reset = 1'b1;
      bus.uart_rxd = 1'b1;
      tick(3);
      chk("midframe_reset_data", 32'(bus.uart_rx_data), 0);
      reset = 1'b0;
      tick(2 * CPB);
      send(8'h7E, 1, 1, 0);
      tick(CPB);
      chk("after_reset_data", 32'(bus.uart_rx_data), 32'h7E);

      bus.uart_rx_en = 1'b0;
      send(8'h99, 1, 1, 0);
      tick(2 * CPB);
      chk("disabled_ignored", 32'(bus.uart_rx_data), 32'h7E);
      bus.uart_rx_en = 1'b1;
      send(8'h42, 1, 1, 1);
      send(8'h24, 1, 1, 0);
      tick(2 * CPB);
      chk("en_drop_completes", 32'(bus.uart_rx_data), 32'h42);
      bus.uart_rx_en = 1'b1;

`ifdef RX_PARITY_EN
      send(8'h07, 1, 0, 0);
      tick(2 * CPB);
      chk("parity_err_keeps_data", 32'(bus.uart_rx_data), 32'h42);
`endif

      for (int n = 0; n < 40; n++) begin
         st = ($urandom_range(0, 7) != 0);
         pa = ($urandom_range(0, 7) != 0);
         en = ($urandom_range(0, 5) != 0);
         dr = ($urandom_range(0, 3) == 0);
         bus.uart_rx_en = en;
         send(PB'($urandom_range(0, 3) == 0 ? 0 : $urandom), st, pa, dr);
         if (!st) tick(CPB + $urandom_range(0, 5));
         else if ($urandom_range(0, 1) == 1) tick($urandom_range(1, 4));
      end

      tick(3 * CPB);
      chk("queue_drained", 32'(expq.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
